// File: rtl/fibre_a_spike_buffer.sv
// Spike-vector buffer for fibre A: a burst loader fills entries, and a fixed 1-cycle read port serves them.
// Reads that miss (buffer not READY, or address beyond the loaded count) return zero data flagged as oob.
//
// state     | meaning
// S_EMPTY   | no valid contents, waiting for load_start
// S_LOADING | accepting load beats into mem[fill_count]
// S_READY   | contents valid for entries below fill_count
module fibre_a_spike_buffer #(
    parameter int TIMESTEPS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load_start,
    input  logic [TIMESTEPS-1:0]  load_data,
    input  logic                  load_valid,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    input  logic                  fibre_a_read_en,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    output logic                  fibre_a_oob,
    output logic                  buf_ready,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_READY
    } state_t;

    state_t state;

    logic [TIMESTEPS-1:0] mem [DEPTH];

    logic                 beat;
    logic [IDX_W-1:0]     wr_idx;
    logic                 rd_hit;
    logic [TIMESTEPS-1:0] rd_word;

    // fill_count doubles as the write pointer; it stays below DEPTH while LOADING
    assign beat    = load_valid && load_ready && !clear && !rst;
    assign wr_idx  = fill_count[IDX_W-1:0];
    assign rd_hit  = (state == S_READY) && ({1'b0, fibre_a_addr} < fill_count);
    assign rd_word = mem[fibre_a_addr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= S_EMPTY;
            load_ready <= 1'b0;
            buf_ready  <= 1'b0;
            fill_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_EMPTY, S_READY: begin
                    if (load_start) begin
                        state      <= S_LOADING;
                        load_ready <= 1'b1;
                        buf_ready  <= 1'b0;
                        fill_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                S_LOADING: begin
                    if (load_valid) begin
                        fill_count <= fill_count + 1'b1;
                        if (load_last || fill_count == LAST_IDX) begin
                            state      <= S_READY;
                            load_ready <= 1'b0;
                            buf_ready  <= 1'b1;
                            overflow   <= !load_last;
                        end
                    end
                end
                default: begin
                    state      <= S_EMPTY;
                    load_ready <= 1'b0;
                    buf_ready  <= 1'b0;
                    fill_count <= '0;
                    overflow   <= 1'b0;
                end
            endcase
        end
    end

    // Read hit is judged against the state before any same-cycle clear or load_start
    always_ff @(posedge clk) begin
        if (rst) begin
            fibre_a_valid <= 1'b0;
            fibre_a_oob   <= 1'b0;
            fibre_a_data  <= '0;
        end else if (fibre_a_read_en) begin
            fibre_a_valid <= 1'b1;
            fibre_a_oob   <= !rd_hit;
            fibre_a_data  <= rd_hit ? rd_word : '0;
        end else begin
            fibre_a_valid <= 1'b0;
            fibre_a_oob   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fibre_a_spike_buffer.sv
// Directed bench for fibre_a_spike_buffer: load, read, overflow, clear and reset scenarios
// with hand-computed expectations.
module tb_fibre_a_spike_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       load_start;
    logic [3:0] load_data;
    logic       load_valid;
    logic       load_last;
    logic       load_ready;
    logic [7:0] fibre_a_addr;
    logic       fibre_a_read_en;
    logic [3:0] fibre_a_data;
    logic       fibre_a_valid;
    logic       fibre_a_oob;
    logic       buf_ready;
    logic [8:0] fill_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fibre_a_spike_buffer #(.TIMESTEPS(4), .ADDR_WIDTH(8), .DEPTH(128)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .load_start(load_start),
        .load_data(load_data),
        .load_valid(load_valid),
        .load_last(load_last),
        .load_ready(load_ready),
        .fibre_a_addr(fibre_a_addr),
        .fibre_a_read_en(fibre_a_read_en),
        .fibre_a_data(fibre_a_data),
        .fibre_a_valid(fibre_a_valid),
        .fibre_a_oob(fibre_a_oob),
        .buf_ready(buf_ready),
        .fill_count(fill_count),
        .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] data, input logic oob);
        check({tag, "_valid"}, 32'(fibre_a_valid), 32'd1);
        check({tag, "_data"}, 32'(fibre_a_data), 32'(data));
        check({tag, "_oob"}, 32'(fibre_a_oob), 32'(oob));
    endtask

    task automatic read(input logic [7:0] addr);
        fibre_a_read_en = 1'b1;
        fibre_a_addr    = addr;
        tick();
        fibre_a_read_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load_start = 1'b0; load_data = '0;
        load_valid = 1'b0; load_last = 1'b0; fibre_a_addr = '0; fibre_a_read_en = 1'b0;
        tick();
        tick();
        check("rst_load_ready", 32'(load_ready), 0);
        check("rst_buf_ready", 32'(buf_ready), 0);
        check("rst_fill", 32'(fill_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_valid", 32'(fibre_a_valid), 0);
        check("rst_oob", 32'(fibre_a_oob), 0);
        check("rst_data", 32'(fibre_a_data), 0);
        rst = 1'b0;

        // empty-state read misses
        read(8'd0);
        check_rsp("empty_read", 4'h0, 1'b1);

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("loading_load_ready", 32'(load_ready), 1);
        check("loading_buf_ready", 32'(buf_ready), 0);

        read(8'd0);
        check_rsp("read_in_loading", 4'h0, 1'b1);
        check("read_in_loading_buf_ready", 32'(buf_ready), 0);

        // basic three-beat load
        load_valid = 1'b1;
        load_data = 4'b1111; tick();
        load_data = 4'b0101; tick();
        load_data = 4'b0010; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("basic_fill", 32'(fill_count), 3);
        check("basic_buf_ready", 32'(buf_ready), 1);
        check("basic_load_ready", 32'(load_ready), 0);
        check("basic_overflow", 32'(overflow), 0);

        read(8'd1);
        check_rsp("read_addr1", 4'b0101, 1'b0);
        tick();
        check("idle_valid", 32'(fibre_a_valid), 0);
        check("idle_oob", 32'(fibre_a_oob), 0);
        check("idle_data_hold", 32'(fibre_a_data), 32'h5);

        // back-to-back reads, including misses at fill_count and beyond DEPTH
        fibre_a_read_en = 1'b1;
        fibre_a_addr = 8'd0;   tick(); check_rsp("b2b_addr0", 4'b1111, 1'b0);
        fibre_a_addr = 8'd2;   tick(); check_rsp("b2b_addr2", 4'b0010, 1'b0);
        fibre_a_addr = 8'd3;   tick(); check_rsp("b2b_addr3", 4'h0, 1'b1);
        fibre_a_addr = 8'd200; tick(); check_rsp("b2b_addr200", 4'h0, 1'b1);
        fibre_a_read_en = 1'b0;

        // beats outside LOADING are ignored
        load_valid = 1'b1; load_data = 4'h7;
        tick();
        load_valid = 1'b0;
        check("ready_beat_ignored_fill", 32'(fill_count), 3);
        read(8'd0);
        check_rsp("ready_beat_ignored_data", 4'b1111, 1'b0);

        // clear with concurrent read sees pre-clear contents
        clear = 1'b1;
        read(8'd0);
        clear = 1'b0;
        check_rsp("clear_read", 4'b1111, 1'b0);
        check("clear_fill", 32'(fill_count), 0);
        check("clear_buf_ready", 32'(buf_ready), 0);
        read(8'd0);
        check_rsp("post_clear_read", 4'h0, 1'b1);

        // overflow: 130 beats, no last; a load_start mid-load must be ignored
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 130; i++) begin
            load_valid = 1'b1;
            load_data  = 4'(i);
            load_start = (i == 5);
            tick();
            if (i == 126) begin
                check("ovf_pre_fill", 32'(fill_count), 127);
                check("ovf_pre_overflow", 32'(overflow), 0);
                check("ovf_pre_load_ready", 32'(load_ready), 1);
            end
        end
        load_valid = 1'b0; load_start = 1'b0;
        check("ovf_load_ready", 32'(load_ready), 0);
        check("ovf_overflow", 32'(overflow), 1);
        check("ovf_fill", 32'(fill_count), 128);
        check("ovf_buf_ready", 32'(buf_ready), 1);
        read(8'd127);
        check_rsp("ovf_read127", 4'hF, 1'b0);
        read(8'd126);
        check_rsp("ovf_read126", 4'hE, 1'b0);
        read(8'd1);
        check_rsp("ovf_read1", 4'h1, 1'b0);
        read(8'd128);
        check_rsp("ovf_read128", 4'h0, 1'b1);

        // restart from READY clears overflow and count
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("restart_overflow", 32'(overflow), 0);
        check("restart_fill", 32'(fill_count), 0);
        check("restart_load_ready", 32'(load_ready), 1);

        // reset during LOADING with a read request and a beat in the same cycle
        rst = 1'b1; load_valid = 1'b1; load_data = 4'h9;
        read(8'd0);
        rst = 1'b0; load_valid = 1'b0;
        check("midrst_valid", 32'(fibre_a_valid), 0);
        check("midrst_load_ready", 32'(load_ready), 0);
        check("midrst_buf_ready", 32'(buf_ready), 0);
        check("midrst_fill", 32'(fill_count), 0);
        read(8'd0);
        check_rsp("midrst_empty_read", 4'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
